// File: rtl/memlcd_pkg.sv
// Shared state encoding, default parameters and width helper for the memory-LCD scan driver.
package memlcd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_LINE_HEAD,
      S_SHIFT,
      S_GEN,
      S_END
   } state_t;

   localparam int unsigned DEF_RGB_WIDTH = 6;
   localparam int unsigned DEF_H_WORDS   = 128;
   localparam int unsigned DEF_LINES     = 240;
   localparam int unsigned DEF_CLK_DIV   = 16;
   localparam int unsigned DEF_GEN_TICKS = 4;
   localparam int unsigned DEF_VCOM_DIV  = 833334;

   // Bounds of 1 still need a 1-bit counter to stay legal.
   function automatic int unsigned cnt_width(input int unsigned bound);
      return (bound > 1) ? $clog2(bound) : 1;
   endfunction

endpackage

// File: rtl/memlcd_tick_gen.sv
// Timing-tick enable: counts 0..CLK_DIV-1 and flags the terminal count as a tick.
module memlcd_tick_gen
   import memlcd_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_hold,
   output logic o_tick
);

   localparam int unsigned CW = cnt_width(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (!i_hold) begin
         r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/memlcd_scan_driver.sv
// Memory-LCD frame scan engine: tick-timed gate/source sequencing fed by a valid/ready pixel stream.
module memlcd_scan_driver
   import memlcd_pkg::*;
#(
   parameter int unsigned RGB_WIDTH = DEF_RGB_WIDTH,
   parameter int unsigned H_WORDS   = DEF_H_WORDS,
   parameter int unsigned LINES     = DEF_LINES,
   parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
   parameter int unsigned GEN_TICKS = DEF_GEN_TICKS,
   parameter int unsigned VCOM_DIV  = DEF_VCOM_DIV
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_frame_start,
   input  logic [RGB_WIDTH-1:0] i_pix_data,
   input  logic                 i_pix_valid,
   output logic                 o_pix_ready,
   output logic                 o_busy,
   output logic                 o_frame_done,
   output logic                 o_underrun,
   output logic                 o_intb,
   output logic                 o_gsp,
   output logic                 o_gck,
   output logic                 o_gen,
   output logic                 o_bsp,
   output logic                 o_bck,
   output logic [RGB_WIDTH-1:0] o_rgb,
   output logic                 o_vcom,
   output logic                 o_va,
   output logic                 o_vb
);

   localparam int unsigned WW = cnt_width(H_WORDS);
   localparam int unsigned LW = cnt_width(LINES);
   localparam int unsigned GW = cnt_width(GEN_TICKS);
   localparam int unsigned VW = cnt_width(VCOM_DIV);
   localparam logic [WW-1:0] WORD_LAST = WW'(H_WORDS - 1);
   localparam logic [WW-1:0] WORD_ONE  = WW'(1);
   localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);
   localparam logic [GW-1:0] GEN_LAST  = GW'(GEN_TICKS - 1);
   localparam logic [VW-1:0] VCOM_LAST = VW'(VCOM_DIV - 1);

   state_t r_state, w_state_nxt;
   logic [LW-1:0] r_line, w_line_nxt;
   logic [WW-1:0] r_word, w_word_nxt;
   logic [GW-1:0] r_gcnt, w_gcnt_nxt;
   logic r_busy, w_busy_nxt, r_done, w_done_nxt, r_underrun, w_underrun_nxt;
   logic r_intb, w_intb_nxt, r_gsp, w_gsp_nxt, r_gck, w_gck_nxt;
   logic r_gen, w_gen_nxt, r_bsp, w_bsp_nxt, r_bck, w_bck_nxt;
   logic [RGB_WIDTH-1:0] r_rgb, w_rgb_nxt;
   logic [VW-1:0] r_vcnt;
   logic r_vcom, r_va;
   logic w_tick, w_clear, w_hold, w_ready;

   memlcd_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (w_clear),
      .i_hold  (w_hold),
      .o_tick  (w_tick)
   );

   assign w_ready = (r_state == S_SHIFT) && w_tick;

   always_comb begin
      w_state_nxt    = r_state;
      w_line_nxt     = r_line;
      w_word_nxt     = r_word;
      w_gcnt_nxt     = r_gcnt;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
      w_underrun_nxt = r_underrun;
      w_intb_nxt     = r_intb;
      w_gsp_nxt      = r_gsp;
      w_gck_nxt      = r_gck;
      w_gen_nxt      = r_gen;
      w_bsp_nxt      = r_bsp;
      w_bck_nxt      = r_bck;
      w_rgb_nxt      = r_rgb;
      w_clear        = 1'b0;
      w_hold         = ~r_busy;
      case (r_state)
         S_IDLE: if (i_frame_start) begin
            w_busy_nxt     = 1'b1;
            w_intb_nxt     = 1'b1;
            w_gsp_nxt      = 1'b1;
            w_underrun_nxt = 1'b0;
            w_clear        = 1'b1;
            w_line_nxt     = '0;
            w_word_nxt     = '0;
            w_gcnt_nxt     = '0;
            w_state_nxt    = S_START;
         end
         S_START: if (w_tick) begin
            w_gck_nxt   = ~r_gck;
            w_bsp_nxt   = 1'b1;
            w_state_nxt = S_LINE_HEAD;
         end
         S_LINE_HEAD: if (w_tick) begin
            if (r_line == '0) w_gsp_nxt = 1'b0;
            w_state_nxt = S_SHIFT;
         end
         // Missing data at the terminal count freezes the tick counter, stretching the scan.
         S_SHIFT: if (w_tick) begin
            if (i_pix_valid) begin
               w_rgb_nxt = i_pix_data;
               w_bck_nxt = ~r_bck;
               if (r_word == WORD_ONE) w_bsp_nxt = 1'b0;
               if (r_word == WORD_LAST) begin
                  w_word_nxt  = '0;
                  w_gen_nxt   = 1'b1;
                  w_state_nxt = S_GEN;
               end else begin
                  w_word_nxt = r_word + 1'b1;
               end
            end else begin
               w_hold         = 1'b1;
               w_underrun_nxt = 1'b1;
            end
         end
         S_GEN: if (w_tick) begin
            if (r_gcnt == GEN_LAST) begin
               w_gcnt_nxt = '0;
               w_gen_nxt  = 1'b0;
               w_gck_nxt  = ~r_gck;
               if (r_line == LINE_LAST) begin
                  w_state_nxt = S_END;
               end else begin
                  w_line_nxt  = r_line + 1'b1;
                  w_bsp_nxt   = 1'b1;
                  w_state_nxt = S_LINE_HEAD;
               end
            end else begin
               w_gcnt_nxt = r_gcnt + 1'b1;
            end
         end
         S_END: if (w_tick) begin
            w_intb_nxt  = 1'b0;
            w_gck_nxt   = 1'b0;
            w_rgb_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_line     <= '0;
         r_word     <= '0;
         r_gcnt     <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_underrun <= 1'b0;
         r_intb     <= 1'b0;
         r_gsp      <= 1'b0;
         r_gck      <= 1'b0;
         r_gen      <= 1'b0;
         r_bsp      <= 1'b0;
         r_bck      <= 1'b0;
         r_rgb      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_line     <= w_line_nxt;
         r_word     <= w_word_nxt;
         r_gcnt     <= w_gcnt_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_underrun <= w_underrun_nxt;
         r_intb     <= w_intb_nxt;
         r_gsp      <= w_gsp_nxt;
         r_gck      <= w_gck_nxt;
         r_gen      <= w_gen_nxt;
         r_bsp      <= w_bsp_nxt;
         r_bck      <= w_bck_nxt;
         r_rgb      <= w_rgb_nxt;
      end
   end

   // VCOM runs from reset regardless of scan activity; VA is kept as its own register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_vcnt <= '0;
         r_vcom <= 1'b0;
         r_va   <= 1'b1;
      end else if (r_vcnt == VCOM_LAST) begin
         r_vcnt <= '0;
         r_vcom <= ~r_vcom;
         r_va   <= r_vcom;
      end else begin
         r_vcnt <= r_vcnt + 1'b1;
      end
   end

   assign o_pix_ready  = w_ready;
   assign o_busy       = r_busy;
   assign o_frame_done = r_done;
   assign o_underrun   = r_underrun;
   assign o_intb       = r_intb;
   assign o_gsp        = r_gsp;
   assign o_gck        = r_gck;
   assign o_gen        = r_gen;
   assign o_bsp        = r_bsp;
   assign o_bck        = r_bck;
   assign o_rgb        = r_rgb;
   assign o_vcom       = r_vcom;
   assign o_va         = r_va;
   assign o_vb         = r_vcom;

endmodule

// File: tb/tb_memlcd_scan_driver.sv
// Scoreboard bench for memlcd_scan_driver using a small 4-word x 2-line panel geometry.
module tb_memlcd_scan_driver;

   localparam int unsigned RGBW = 6;
   localparam int unsigned HW   = 4;
   localparam int unsigned NL   = 2;
   localparam int unsigned CD   = 4;
   localparam int unsigned GT   = 2;
   localparam int unsigned VD   = 10;

   logic clk, rst, fs, pvalid;
   logic [RGBW-1:0] pdata;
   logic o_pix_ready, o_busy, o_frame_done, o_underrun;
   logic o_intb, o_gsp, o_gck, o_gen, o_bsp, o_bck;
   logic [RGBW-1:0] o_rgb;
   logic o_vcom, o_va, o_vb;

   memlcd_scan_driver #(
      .RGB_WIDTH (RGBW),
      .H_WORDS   (HW),
      .LINES     (NL),
      .CLK_DIV   (CD),
      .GEN_TICKS (GT),
      .VCOM_DIV  (VD)
   ) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_frame_start (fs),
      .i_pix_data    (pdata),
      .i_pix_valid   (pvalid),
      .o_pix_ready   (o_pix_ready),
      .o_busy        (o_busy),
      .o_frame_done  (o_frame_done),
      .o_underrun    (o_underrun),
      .o_intb        (o_intb),
      .o_gsp         (o_gsp),
      .o_gck         (o_gck),
      .o_gen         (o_gen),
      .o_bsp         (o_bsp),
      .o_bck         (o_bck),
      .o_rgb         (o_rgb),
      .o_vcom        (o_vcom),
      .o_va          (o_va),
      .o_vb          (o_vb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int k, done_edge, done_cnt, n_xfer, data_idx, word_in_line;
   int bck_toggles, gck_toggles, gen_cycles, bsp_cycles, gsp_cycles;
   logic prev_bck, prev_gck, stall_bck;
   logic [RGBW-1:0] exp_q[$];

   // One clock: handshake sampled at the negedge, DUT observed at the following negedge.
   task automatic step();
      logic xfer;
      logic [RGBW-1:0] e;
      xfer = pvalid && o_pix_ready;
      if (xfer) begin
         exp_q.push_back(pdata);
         n_xfer++;
      end
      @(posedge clk);
      #1;
      k++;
      if (xfer) begin
         data_idx++;
         pdata = RGBW'(data_idx + 1);
      end
      @(negedge clk);
      if (o_bck !== prev_bck) begin
         prev_bck = o_bck;
         bck_toggles++;
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL rgb_unexpected: got %0h required none (edge %0d)", o_rgb, k);
         end else begin
            e = exp_q.pop_front();
            if (o_rgb !== e) $display("FAIL rgb_data: got %0h required %0h (edge %0d)", o_rgb, e, k);
            else n_pass++;
         end
         n_total++;
         if (o_bsp !== (word_in_line == 0))
            $display("FAIL bsp_word: got %b required %b (word %0d)", o_bsp, (word_in_line == 0), word_in_line);
         else n_pass++;
         word_in_line = (word_in_line + 1) % HW;
      end
      if (o_gck !== prev_gck) begin
         prev_gck = o_gck;
         if (!o_frame_done) gck_toggles++;
      end
      if (o_gen) gen_cycles++;
      if (o_bsp) bsp_cycles++;
      if (o_gsp) gsp_cycles++;
      if (o_frame_done) begin
         done_cnt++;
         if (done_edge < 0) done_edge = k;
      end
      n_total++;
      if ({o_va, o_vb} !== {~o_vcom, o_vcom})
         $display("FAIL va_vb: got %b%b required %b%b", o_va, o_vb, ~o_vcom, o_vcom);
      else n_pass++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      fs = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      k = 0;
      exp_q.delete();
      prev_bck = o_bck;
      prev_gck = o_gck;
      word_in_line = 0;
   endtask

   task automatic clear_stats();
      done_edge = -1;
      done_cnt = 0;
      n_xfer = 0;
      bck_toggles = 0;
      gck_toggles = 0;
      gen_cycles = 0;
      bsp_cycles = 0;
      gsp_cycles = 0;
      word_in_line = 0;
      data_idx = 0;
      pdata = RGBW'(1);
   endtask

   task automatic start_frame();
      clear_stats();
      fs = 1'b1;
      step();
      fs = 1'b0;
      k = 0;
   endtask

   task automatic run_until_done(input int limit);
      while (done_edge < 0 && k < limit) step();
   endtask

   task automatic test_reset();
      logic exp_vcom;
      do_reset();
      clear_stats();
      n_total++;
      if ({o_busy, o_frame_done, o_underrun, o_intb, o_gsp, o_gck, o_gen, o_bsp, o_bck,
           o_pix_ready, o_vcom, o_va, o_vb} !== 13'h002)
         $display("FAIL reset_outputs: got %b required %b", {o_busy, o_frame_done, o_underrun,
                  o_intb, o_gsp, o_gck, o_gen, o_bsp, o_bck, o_pix_ready, o_vcom, o_va, o_vb}, 13'h002);
      else n_pass++;
      n_total++;
      if (o_rgb !== '0) $display("FAIL reset_rgb: got %0h required 0", o_rgb);
      else n_pass++;
      for (int n = 1; n <= 25; n++) begin
         step();
         exp_vcom = ((k / VD) % 2) == 1;
         n_total++;
         if (o_vcom !== exp_vcom) $display("FAIL vcom_idle: got %b required %b (cycle %0d)", o_vcom, exp_vcom, k);
         else n_pass++;
      end
      n_total++;
      if ({o_intb, o_busy, o_gsp, o_gck, o_gen, o_bsp, o_bck, o_pix_ready} !== 8'h00 || o_rgb !== '0)
         $display("FAIL idle_panel: got %b/%0h required 00000000/0",
                  {o_intb, o_busy, o_gsp, o_gck, o_gen, o_bsp, o_bck, o_pix_ready}, o_rgb);
      else n_pass++;
      n_total++;
      if (n_xfer !== 0) $display("FAIL idle_accept: got %0d required 0", n_xfer);
      else n_pass++;
   endtask

   task automatic test_frame();
      do_reset();
      pvalid = 1'b1;
      start_frame();
      n_total++;
      if ({o_busy, o_intb, o_gsp} !== 3'b111) $display("FAIL start_flags: got %b required 111", {o_busy, o_intb, o_gsp});
      else n_pass++;
      run_until_done(200);
      n_total++;
      if (done_edge !== 64) $display("FAIL frame_len: got %0d required 64", done_edge);
      else n_pass++;
      n_total++;
      if (n_xfer !== 8) $display("FAIL frame_xfers: got %0d required 8", n_xfer);
      else n_pass++;
      n_total++;
      if (bck_toggles !== 8) $display("FAIL bck_toggles: got %0d required 8", bck_toggles);
      else n_pass++;
      n_total++;
      if (gck_toggles !== 3 || o_gck !== 1'b0) $display("FAIL gck_seq: got %0d/%b required 3/0", gck_toggles, o_gck);
      else n_pass++;
      n_total++;
      if (gen_cycles !== 16) $display("FAIL gen_cycles: got %0d required 16", gen_cycles);
      else n_pass++;
      n_total++;
      if (bsp_cycles !== 24) $display("FAIL bsp_cycles: got %0d required 24", bsp_cycles);
      else n_pass++;
      n_total++;
      if (gsp_cycles !== 8) $display("FAIL gsp_cycles: got %0d required 8", gsp_cycles);
      else n_pass++;
      n_total++;
      if ({o_underrun, o_busy, o_intb, o_bck} !== 4'b0000 || o_rgb !== '0)
         $display("FAIL frame_end: got %b/%0h required 0000/0", {o_underrun, o_busy, o_intb, o_bck}, o_rgb);
      else n_pass++;
      n_total++;
      if (exp_q.size() != 0) $display("FAIL rgb_missing: got %0d pending required 0", exp_q.size());
      else n_pass++;
      step();
      n_total++;
      if (o_frame_done !== 1'b0) $display("FAIL done_pulse: got %b required 0", o_frame_done);
      else n_pass++;
   endtask

   task automatic test_stall();
      do_reset();
      pvalid = 1'b1;
      start_frame();
      while (done_edge < 0 && k < 200) begin
         if (k >= 19 && k < 24) begin
            pvalid = 1'b0;
            n_total++;
            if (o_pix_ready !== 1'b1) $display("FAIL stall_ready: got %b required 1 (cycle %0d)", o_pix_ready, k);
            else n_pass++;
            if (k == 19) begin
               stall_bck = o_bck;
            end else begin
               n_total++;
               if (o_bck !== stall_bck || o_underrun !== 1'b1)
                  $display("FAIL stall_hold: got bck=%b underrun=%b required bck=%b underrun=1", o_bck, o_underrun, stall_bck);
               else n_pass++;
            end
         end else begin
            pvalid = 1'b1;
         end
         step();
      end
      pvalid = 1'b1;
      n_total++;
      if (done_edge !== 69) $display("FAIL stall_len: got %0d required 69", done_edge);
      else n_pass++;
      n_total++;
      if (o_underrun !== 1'b1) $display("FAIL underrun_sticky: got %b required 1", o_underrun);
      else n_pass++;
      n_total++;
      if (n_xfer !== 8 || bck_toggles !== 8) $display("FAIL stall_xfers: got %0d/%0d required 8/8", n_xfer, bck_toggles);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      pvalid = 1'b1;
      start_frame();
      while (done_edge < 0 && k < 200) begin
         fs = (k == 29);
         step();
      end
      fs = 1'b0;
      n_total++;
      if (done_edge !== 64) $display("FAIL busy_ignore_len: got %0d required 64", done_edge);
      else n_pass++;
      repeat (20) step();
      n_total++;
      if ({o_busy, o_intb, o_gsp} !== 3'b000 || done_cnt !== 1 || n_xfer !== 8)
         $display("FAIL no_second_frame: got %b done=%0d xfers=%0d required 000 done=1 xfers=8",
                  {o_busy, o_intb, o_gsp}, done_cnt, n_xfer);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      pvalid = 1'b1;
      start_frame();
      while (done_edge < 0 && k < 39) step();
      n_total++;
      if ({o_busy, o_intb} !== 2'b11) $display("FAIL pre_reset_busy: got %b required 11", {o_busy, o_intb});
      else n_pass++;
      do_reset();
      n_total++;
      if ({o_busy, o_frame_done, o_underrun, o_intb, o_gsp, o_gck, o_gen, o_bsp, o_bck,
           o_pix_ready, o_vcom, o_va, o_vb} !== 13'h002 || o_rgb !== '0)
         $display("FAIL midreset_outputs: got %b/%0h required %b/0", {o_busy, o_frame_done, o_underrun,
                  o_intb, o_gsp, o_gck, o_gen, o_bsp, o_bck, o_pix_ready, o_vcom, o_va, o_vb}, o_rgb, 13'h002);
      else n_pass++;
      start_frame();
      run_until_done(200);
      n_total++;
      if (done_edge !== 64) $display("FAIL refresh_len: got %0d required 64", done_edge);
      else n_pass++;
      n_total++;
      if (n_xfer !== 8 || o_underrun !== 1'b0) $display("FAIL refresh_xfers: got %0d/%b required 8/0", n_xfer, o_underrun);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      fs = 1'b0;
      pvalid = 1'b1;
      pdata = '0;
      k = 0;
      clear_stats();
      test_reset();
      test_frame();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/memlcd_scan_driver.md
# memlcd_scan_driver

Parametrised memory-LCD panel scan engine with a single clock domain. It replaces divided-clock LCD timing with tick-enable timing and consumes pixel words over a valid/ready stream, normally fed from the async FIFO read side. On request it generates one full frame of gate/source timing (INTB, GSP, GCK, BSP, BCK, GEN, RGB) and free-running VCOM/VA/VB. When the pixel source underruns, it stalls the scan and flags the underrun.

## Interface
- RGB_WIDTH, 6: pixel word width per BCK edge.
- H_WORDS, 128: BCK half-periods (pixel words) per line; must be even and ≥2.
- LINES, 240: lines per frame; ≥1.
- CLK_DIV, 16: i_clk cycles per timing tick; ≥2.
- GEN_TICKS, 4: ticks GEN is held high per line; ≥1.
- VCOM_DIV, 833334: i_clk cycles between VCOM toggles (≈60 Hz square wave at 100 MHz).
- i_clk  in  1  system clock; one clock; reset is synchronous and active-high.
- i_reset  in  1  synchronous, active-high reset.
- i_frame_start  in  1  one-cycle request to scan a frame; ignored unless idle.
- i_pix_data  in  RGB_WIDTH  pixel word.
- i_pix_valid  in  1  pixel word available.
- o_pix_ready  out  1  driver accepts a word this cycle.
- o_busy  out  1  frame in progress.
- o_frame_done  out  1  one-cycle pulse at frame end.
- o_underrun  out  1  sticky: at least one tick stalled for data this frame.
- o_intb, o_gsp, o_gck, o_gen, o_bsp, o_bck  out  1 each  panel timing.
- o_rgb  out  RGB_WIDTH  panel data.
- o_vcom, o_va, o_vb  out  1 each  o_va = ~o_vcom, o_vb = o_vcom.

## Operation
- Reset values: every output is 0 except o_va = 1. State is IDLE and all counters are 0.
- Tick counter: cleared on the accepting edge of i_frame_start. It counts 0..CLK_DIV-1 and issues a tick when cnt == CLK_DIV-1, then wraps. It runs only while busy.
- States: IDLE → START → LINE_HEAD → SHIFT → GEN → (LINE_HEAD | END) → IDLE.
- IDLE, i_frame_start = 1: set o_busy = 1, o_intb = 1, o_gsp = 1, clear o_underrun, go to START.
- START tick: go to LINE_HEAD, toggle o_gck, set o_bsp = 1.
- LINE_HEAD tick: go to SHIFT. On line 0, also set o_gsp = 0.
- SHIFT:
  - o_pix_ready = (cnt == CLK_DIV-1), combinational.
  - A transfer occurs when valid and ready are both high. On that edge: o_rgb ← i_pix_data, toggle o_bck, cnt wraps. On the transfer of word index 1, set o_bsp = 0.
  - Stall: if cnt == CLK_DIV-1 and i_pix_valid = 0, cnt holds, o_underrun is set, and the state does not advance.
  - After transfer H_WORDS-1: go to GEN and set o_gen = 1.
- GEN: after GEN_TICKS ticks, set o_gen = 0 and toggle o_gck.
  - If the last line is done, go to END.
  - Otherwise increment the line counter, go to LINE_HEAD, and set o_bsp = 1.
- END tick: set o_intb = 0, o_gck = 0, o_rgb = 0, o_busy = 0, pulse o_frame_done, go to IDLE.
- VCOM: independent counter, active from reset, not gated by o_busy. o_vcom toggles every VCOM_DIV cycles.
- Boundaries:
  - i_frame_start while busy is ignored, with no queuing.
  - Reset mid-frame forces all reset values on the next edge and drops any in-flight word.
  - i_pix_valid outside SHIFT is never acknowledged.
  - o_bck ends each line at 0 because H_WORDS is even.

## Timing
- All outputs are registered except o_pix_ready.
- Stall-free frame length: (2 + LINES·(1 + H_WORDS + GEN_TICKS))·CLK_DIV cycles from the accepting edge to the edge that raises o_frame_done.
- Each stalled cycle adds exactly 1 cycle to that length.
- Pixel latency: o_rgb updates on the transfer edge.
- Counter widths are $clog2 of each bound. The VCOM counter is $clog2(VCOM_DIV).

## Structure
- Package memlcd_pkg holds the state enum and default parameter constants.
- Sub-module memlcd_tick_gen holds the tick counter, with inputs clear and hold and output tick.
- The FSM, line/word/GEN counters and VCOM divider are inline.

## Test plan
All scenarios use RGB_WIDTH=6, H_WORDS=4, LINES=2, CLK_DIV=4, GEN_TICKS=2, VCOM_DIV=10, and i_pix_valid held at 1 unless stated.
- Reset, then idle for 25 cycles → all panel outputs 0; o_vcom toggles at cycles 10 and 20; o_va = ~o_vcom.
- i_frame_start at cycle 0 → o_intb/o_gsp high at edge 0; o_frame_done at edge 64; exactly 8 transfers; o_gck toggles 3 times then returns to 0; o_underrun = 0.
- Data 0x01..0x08 → o_rgb shows the same sequence. o_bck toggles 4 times per line. o_bsp is high only through the first word of each line. o_gen is high for 8 cycles per line.
- i_pix_valid dropped for 5 cycles during the third word → o_pix_ready held high, o_bck frozen, o_underrun = 1, o_frame_done at edge 69.
- i_frame_start pulsed again at cycle 30 → ignored; frame still ends at edge 64; no second frame starts.
- i_reset at cycle 40 mid-SHIFT → next edge: all outputs at reset values, o_busy = 0; a new i_frame_start produces a full 64-cycle frame.
